// File: rtl/seq_isqrt_pkg.sv
// seq_isqrt_pkg: shared state type and width helpers for the sequential integer square root.
package seq_isqrt_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} isqrt_state_t;

    // Radicand bits consumed per iteration.
    localparam int unsigned ISQRT_BITS_PER_STEP = 2;

    function automatic int unsigned isqrt_root_w(input int unsigned w);
        return w / 2;
    endfunction

    function automatic int unsigned isqrt_rem_w(input int unsigned w);
        return w / 2 + 1;
    endfunction

    // The iteration counter counts down from this value to zero.
    function automatic int unsigned isqrt_last_iter(input int unsigned w);
        return w / 2 - 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational digit-by-digit square-root iteration.
module isqrt_step #(
    parameter int unsigned RW = 4,
    parameter int unsigned MW = RW + 1
) (
    input  logic [MW:0]   i_rem,
    input  logic [RW-1:0] i_root,
    input  logic [1:0]    i_bits,
    output logic [MW:0]   o_rem,
    output logic [RW-1:0] o_root
);

    logic [MW:0] w_rem_sh;
    logic [MW:0] w_trial;
    logic        w_take;

    assign w_rem_sh = (i_rem << 2) | (MW+1)'(i_bits);
    assign w_trial  = (MW+1)'({i_root, 2'b01});
    assign w_take   = (w_rem_sh >= w_trial);

    assign o_rem  = w_take ? (w_rem_sh - w_trial) : w_rem_sh;
    assign o_root = (i_root << 1) | RW'(w_take);

endmodule

// File: rtl/seq_isqrt.sv
// seq_isqrt: multi-cycle floor(sqrt(X)) with remainder, valid/ready on both sides.
// Optional self-check output chk_err when SEQ_ISQRT_CHECK_EN is defined.
module seq_isqrt
    import seq_isqrt_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_x,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [isqrt_root_w(W)-1:0]   out_root,
    output logic [isqrt_rem_w(W)-1:0]    out_rem
`ifdef SEQ_ISQRT_CHECK_EN
    ,
    output logic                         chk_err
`endif
);

    localparam int unsigned RW = isqrt_root_w(W);
    localparam int unsigned MW = isqrt_rem_w(W);
    localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;

    isqrt_state_t  r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [RW-1:0] r_out_root;
    logic [MW-1:0] r_out_rem;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_shift;
    logic [MW:0]   r_rem;
    logic [RW-1:0] r_root;

    logic [MW:0]   w_rem_nxt;
    logic [RW-1:0] w_root_nxt;
    logic          w_last;

    isqrt_step #(
        .RW(RW),
        .MW(MW)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_shift[W-1 -: ISQRT_BITS_PER_STEP]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    assign w_last = (r_state == CALC) && (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_root  <= '0;
            r_out_rem   <= '0;
            r_count     <= '0;
            r_shift     <= '0;
            r_rem       <= '0;
            r_root      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_shift    <= in_x;
                        r_rem      <= '0;
                        r_root     <= '0;
                        r_count    <= CW'(isqrt_last_iter(W));
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_shift <= r_shift << ISQRT_BITS_PER_STEP;
                    r_rem   <= w_rem_nxt;
                    r_root  <= w_root_nxt;
                    if (r_count == '0) begin
                        // Results are captured straight from the final step so out_valid rises on this edge.
                        r_out_valid <= 1'b1;
                        r_out_root  <= w_root_nxt;
                        r_out_rem   <= w_rem_nxt[MW-1:0];
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_root  = r_out_root;
    assign out_rem   = r_out_rem;

`ifdef SEQ_ISQRT_CHECK_EN
    logic [W-1:0]  r_x;
    logic          r_chk_err;
    logic [W-1:0]  w_sq;
    logic [MW-1:0] w_rem_out;
    logic          w_chk;

    assign w_rem_out = w_rem_nxt[MW-1:0];

    // Shift-and-add array multiplier squaring the final root.
    always_comb begin
        w_sq = '0;
        for (int unsigned i = 0; i < RW; i++) begin
            if (w_root_nxt[i]) begin
                w_sq = w_sq + (W'(w_root_nxt) << i);
            end
        end
    end

    assign w_chk = (({1'b0, w_sq} + (W+1)'(w_rem_out)) != {1'b0, r_x})
                || (w_rem_out > {w_root_nxt, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid && r_in_ready) begin
                r_x <= in_x;
            end
            if (w_last) begin
                r_chk_err <= w_chk;
            end else if (r_state == DONE && out_ready) begin
                r_chk_err <= 1'b0;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    logic w_unused;
    assign w_unused = w_last;
`endif

endmodule

// File: tb/tb_seq_isqrt.sv
// tb_seq_isqrt: table vectors, handshake corner cases, exhaustive and randomized streams vs a search-based model.
module tb_seq_isqrt;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = W / 2;
    localparam int unsigned MW = W / 2 + 1;
    localparam int unsigned LAT = RW + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_root;
    logic [MW-1:0] out_rem;
`ifdef SEQ_ISQRT_CHECK_EN
    logic          chk_err;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    seq_isqrt #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem)
`ifdef SEQ_ISQRT_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned x;
        int unsigned root;
        int unsigned rem;
    } vec_t;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= x, found by upward search.
    function automatic void isqrt_ref(input int unsigned x, output int unsigned r, output int unsigned m);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        m = x - r * r;
    endfunction

    task automatic do_accept(input int unsigned x, output bit ok);
        ok = 1'b0;
        in_x = W'(x);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_x = 8'hA5;
    endtask

    task automatic wait_out(output int unsigned lat);
        lat = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic stream(input bit rnd, input int unsigned n);
        int unsigned q[$];
        int unsigned sent, got, cyc, last_acc, bad_gap, x, er, em;
        bit have_acc, acc;
        sent = 0; got = 0; cyc = 0; last_acc = 0; bad_gap = 0; have_acc = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (got < n && cyc < n * 24 + 100) begin
            @(negedge clk);
            cyc++;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_x = rnd ? W'($urandom_range(0, 255)) : W'(sent);
                in_valid = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("out_has_pending", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    x = q.pop_front();
                    isqrt_ref(x, er, em);
                    chk($sformatf("root_x%0d", x), out_root, er);
                    chk($sformatf("rem_x%0d", x), out_rem, em);
`ifdef SEQ_ISQRT_CHECK_EN
                    chk($sformatf("chk_err_x%0d", x), chk_err, 0);
`endif
                    got++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(in_x);
                if (have_acc && (cyc - last_acc) != RW + 2) bad_gap++;
                last_acc = cyc;
                have_acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
                in_x = W'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, n);
        if (!rnd) chk("throughput_gaps", bad_gap, 0);
    endtask

    initial begin
        vec_t tbl[5];
        bit ok;
        int unsigned lat;

        tbl[0] = '{x: 0,   root: 0,  rem: 0};
        tbl[1] = '{x: 144, root: 12, rem: 0};
        tbl[2] = '{x: 200, root: 14, rem: 4};
        tbl[3] = '{x: 255, root: 15, rem: 30};
        tbl[4] = '{x: 1,   root: 1,  rem: 0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        out_ready = 1'b1;
        #23;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_root", out_root, 0);
        chk("rst_out_rem", out_rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            do_accept(tbl[i].x, ok);
            chk("tbl_accept", ok, 1);
            wait_out(lat);
            chk($sformatf("tbl_lat_x%0d", tbl[i].x), lat, LAT);
            chk($sformatf("tbl_root_x%0d", tbl[i].x), out_root, tbl[i].root);
            chk($sformatf("tbl_rem_x%0d", tbl[i].x), out_rem, tbl[i].rem);
            chk("tbl_in_ready_done", in_ready, 0);
            @(posedge clk);
            #1;
            chk("tbl_out_valid_drop", out_valid, 0);
            chk("tbl_in_ready_back", in_ready, 1);
        end

        // Held result with a stalled consumer and a pending new radicand.
        out_ready = 1'b0;
        do_accept(99, ok);
        chk("hold_accept", ok, 1);
        wait_out(lat);
        chk("hold_lat", lat, LAT);
        in_x = 8'd16;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_root", out_root, 9);
            chk("hold_rem", out_rem, 18);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        do_accept(16, ok);
        chk("after_hold_accept", ok, 1);
        wait_out(lat);
        chk("after_hold_lat", lat, LAT);
        chk("after_hold_root", out_root, 4);
        chk("after_hold_rem", out_rem, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the second CALC cycle.
        do_accept(225, ok);
        chk("abort_accept", ok, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_root", out_root, 0);
        chk("abort_rem", out_rem, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_hold_out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_post_in_ready", in_ready, 1);
        do_accept(225, ok);
        chk("abort_retry_accept", ok, 1);
        wait_out(lat);
        chk("abort_retry_lat", lat, LAT);
        chk("abort_retry_root", out_root, 15);
        chk("abort_retry_rem", out_rem, 0);
        @(posedge clk);
        #1;

        stream(1'b0, 256);
        stream(1'b1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_isqrt.md
Name: seq_isqrt

Overview:
- Multi-cycle integer square-root unit: the inverse of the team's combinational squarer/modulus datapath.
- Given an unsigned radicand X, it returns root R = floor(sqrt(X)) and remainder M = X - R*R.
- Uses one digit-by-digit iteration per clock and a valid/ready handshake on both sides.
- Sits beside the ALU as a multi-cycle functional unit for the multi-cycle processor.

Parameters:
- W, 8, radicand width in bits; must be even and >= 4.
- RW, W/2, root width; derived, not overridable.
- MW, W/2+1, remainder width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  radicand valid.
- in_ready  out  1  unit can accept a radicand.
- in_x  in  W  unsigned radicand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_root  out  RW  floor(sqrt(in_x)).
- out_rem  out  MW  in_x - out_root^2.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values while rst_n=0: state=IDLE, in_ready=0, out_valid=0, out_root=0, out_rem=0, iteration counter=0. After reset release, in_ready=1 from the first cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_x into a shift register, clear the partial remainder (MW+1 bits) and partial root (RW bits), set count=RW-1, go to CALC.
- CALC (in_ready=0), one step per edge:
  - rem' = (rem<<2) | two MSBs of the shift register; then shift the register left by 2.
  - trial = (root<<2)|1, zero-extended to MW+1 bits.
  - If rem' >= trial: rem = rem' - trial and root = (root<<1)|1. Otherwise rem = rem' and root = root<<1.
  - When count==0, go to DONE after this step; otherwise decrement count.
- DONE:
  - out_valid=1, with out_root and out_rem registered and stable.
  - On out_ready=1: out_valid drops on the next edge and the FSM returns to IDLE.
  - While out_ready=0: hold all outputs indefinitely.
- Latency: accept edge to out_valid high is RW+1 edges (5 for W=8).
- Throughput: one result per RW+2 cycles. No overlap; in_ready=0 in both CALC and DONE.
- Width rules:
  - Internal remainder is MW+1 bits so the pre-subtract shift cannot overflow.
  - The final remainder always fits MW bits (max 2R); out_rem takes its low MW bits.
- Boundaries:
  - X=0 gives R=0, M=0.
  - X=2^W-1 gives R=2^RW-1, M=2^(RW+1)-2.
  - in_x changing after acceptance has no effect.
  - in_valid held high across DONE is not accepted until IDLE.
- Reset mid-CALC or mid-DONE aborts immediately: outputs return to reset values and no partial result is ever presented.

Optional Feature:
- Macro: SEQ_ISQRT_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit), registered and valid with out_valid, reset 0.
  - chk_err=1 iff out_root*out_root + out_rem != latched X, or out_rem > 2*out_root.
  - The squaring uses a combinational RW x RW array multiplier.
  - Any chk_err=1 is a design bug.
- Undefined: the port and the checker logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_isqrt_pkg:
  - state enum isqrt_state_t {IDLE, CALC, DONE}.
  - localparam function for derived RW/MW.
  - Iteration count constant.
- One sub-module, isqrt_step:
  - Combinational single iteration.
  - Inputs: rem, root, 2 radicand bits.
  - Outputs: next rem, next root.
  - Instantiated once and reused each CALC cycle.
- The checker squarer, when enabled, lives inline under the macro.

Test Plan:
- Reset then X=0, out_ready=1: out_valid on the 5th edge after accept, with root=0, rem=0; in_ready returns to 1.
- X=144 -> root=12, rem=0. X=200 -> root=14, rem=4. X=255 -> root=15, rem=30 (maximum remainder).
- X=99 with out_ready held 0 for 10 cycles:
  - root=9, rem=18 stay stable and out_valid stays 1.
  - in_ready stays 0 with in_valid asserted and a new in_x=16 not accepted.
  - After out_ready=1, the next transaction computes 16 -> root=4, rem=0.
- Assert rst_n=0 asynchronously on the 2nd CALC cycle of X=225:
  - Outputs zero immediately.
  - After release, X=225 -> root=15, rem=0 with correct latency.
- Exhaustive sweep X=0..255, back-to-back with in_valid and out_ready high:
  - Every result matches floor(sqrt) and remainder.
  - With SEQ_ISQRT_CHECK_EN defined, chk_err is never 1.
